// File: rtl/serial_parity_pkg.sv
// Shared types and helpers for the serial parity framer.
package serial_parity_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, CHECK, HOLD} state_t;

    function automatic int cnt_width(int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/parity_bit_cell.sv
// One-bit XOR accumulator: folds d_i in when enabled; sync clear wins over enable.
module parity_bit_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    input  logic d_i,
    output logic acc_o
);

    logic acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     acc_q <= 1'b0;
        else if (clr_i) acc_q <= 1'b0;
        else if (en_i)  acc_q <= acc_q ^ d_i;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/serial_parity_framer.sv
// Serial-bit even-parity framer: one parity/length result per frame on a valid/ready port.
// Optional trailing check bit and down_err output when SERIAL_PARITY_CHECK_EN is defined.
module serial_parity_framer
    import serial_parity_pkg::*;
#(
    parameter int  FRAME_LEN = 8,
    localparam int CNT_W     = cnt_width(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_vld,
    input  logic             up_data,
    input  logic             up_last,
    output logic             up_rdy,
    output logic             down_vld,
    input  logic             down_rdy,
    output logic             down_parity,
    output logic [CNT_W-1:0] down_len
`ifdef SERIAL_PARITY_CHECK_EN
    ,
    output logic             down_err
`endif
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               par_q, par_d;
    logic               vld_q, vld_d;
    logic               acc, acc_en, acc_clr;
    logic               accept, last_bit;
`ifdef SERIAL_PARITY_CHECK_EN
    logic               err_q, err_d;
`endif

    parity_bit_cell u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (acc_en),
        .clr_i (acc_clr),
        .d_i   (up_data),
        .acc_o (acc)
    );

    // Held low through reset so nothing is accepted while the block is still clearing.
    assign up_rdy   = rst_n & (state_q != HOLD);
    assign accept   = up_vld & up_rdy;
    assign last_bit = up_last | (cnt_q == CNT_W'(FRAME_LEN - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        par_d   = par_q;
        vld_d   = vld_q;
        acc_en  = 1'b0;
        acc_clr = 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (last_bit) begin
                        acc_clr = 1'b1;
                        cnt_d   = '0;
                        par_d   = acc ^ up_data;
                        len_d   = cnt_q + CNT_W'(1);
`ifdef SERIAL_PARITY_CHECK_EN
                        // Result is parked here; it becomes valid once the check bit lands.
                        state_d = CHECK;
`else
                        vld_d   = 1'b1;
                        state_d = HOLD;
`endif
                    end else begin
                        acc_en  = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ACCUM;
                    end
                end
            end
            CHECK: begin
`ifdef SERIAL_PARITY_CHECK_EN
                if (accept) begin
                    err_d   = up_data ^ par_q;
                    vld_d   = 1'b1;
                    state_d = HOLD;
                end
`else
                state_d = IDLE;
`endif
            end
            HOLD: begin
                if (down_rdy) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            par_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            par_q   <= par_d;
            vld_q   <= vld_d;
        end
    end

`ifdef SERIAL_PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign down_err = err_q;
`endif

    assign down_vld    = vld_q;
    assign down_parity = par_q;
    assign down_len    = len_q;

endmodule

// File: tb/tb_serial_parity_framer.sv
// Self-checking bench for serial_parity_framer: frame table plus reset, latency,
// backpressure and bubble sequences; results checked through an expectation queue.
module tb_serial_parity_framer;

    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             up_vld = 1'b0, up_data = 1'b0, up_last = 1'b0;
    logic             up_rdy;
    logic             down_vld;
    logic             down_rdy = 1'b0;
    logic             down_parity;
    logic [CNT_W-1:0] down_len;
`ifdef SERIAL_PARITY_CHECK_EN
    logic             down_err;
`endif

    serial_parity_framer #(.FRAME_LEN(FRAME_LEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .up_vld      (up_vld),
        .up_data     (up_data),
        .up_last     (up_last),
        .up_rdy      (up_rdy),
        .down_vld    (down_vld),
        .down_rdy    (down_rdy),
        .down_parity (down_parity),
        .down_len    (down_len)
`ifdef SERIAL_PARITY_CHECK_EN
        ,
        .down_err    (down_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bits;   // sent MSB-first from bits[n-1]
        int         n;
        logic       use_last;
        logic       chk;    // trailing check bit (check build only)
        logic       exp_par;
        int         exp_len;
        logic       exp_err;
    } frame_t;

    typedef struct {
        logic par;
        int   len;
        logic err;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result monitor: a handshake happens at the next posedge when both are high here.
    always @(negedge clk) begin
        if (rst_n && down_vld && down_rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("down_parity", int'(down_parity), int'(e.par));
                chk("down_len", int'(down_len), e.len);
`ifdef SERIAL_PARITY_CHECK_EN
                chk("down_err", int'(down_err), int'(e.err));
`endif
            end
        end
    end

    task automatic send_bit(input logic d, input logic l, output int waits);
        bit ok;
        ok    = 1'b0;
        waits = 0;
        up_vld = 1'b1; up_data = d; up_last = l;
        while (!ok && waits < 64) begin
            @(negedge clk);
            if (up_rdy) ok = 1'b1;
            else        waits++;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        up_vld = 1'b0; up_last = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input int max_gap, output int w0);
        exp_t e;
        int   w;
        e.par = f.exp_par; e.len = f.exp_len; e.err = f.exp_err;
        sb.push_back(e);
        w0 = 0;
        for (int i = 0; i < f.n; i++) begin
            for (int g = $urandom_range(0, max_gap); g > 0; g--) begin
                up_vld = 1'b0; up_data = 1'($urandom); up_last = 1'($urandom);
                @(posedge clk); #1;
            end
            send_bit(f.bits[f.n-1-i], f.use_last && (i == f.n - 1), w);
            if (i == 0) w0 = w;
        end
`ifdef SERIAL_PARITY_CHECK_EN
        send_bit(f.chk, 1'b1, w);
`endif
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("results_drained", sb.size(), 0);
    endtask

    frame_t tbl[$];
    frame_t f;
    int     w0;

    initial begin
        tbl.push_back('{8'b1111_1111, 8, 1'b0, 1'b0, 1'b0, 8, 1'b0});
        tbl.push_back('{8'b0000_0101, 3, 1'b1, 1'b1, 1'b0, 3, 1'b1});
        tbl.push_back('{8'b0000_0001, 1, 1'b1, 1'b1, 1'b1, 1, 1'b0});
        tbl.push_back('{8'b1011_0000, 8, 1'b0, 1'b0, 1'b1, 8, 1'b1});
        tbl.push_back('{8'b0000_0000, 8, 1'b0, 1'b0, 1'b0, 8, 1'b0});
        tbl.push_back('{8'b0000_1101, 5, 1'b1, 1'b0, 1'b1, 5, 1'b1});
        tbl.push_back('{8'b1100_0001, 8, 1'b0, 1'b1, 1'b1, 8, 1'b0});
        tbl.push_back('{8'b1100_0001, 8, 1'b0, 1'b0, 1'b1, 8, 1'b1});
        tbl.push_back('{8'b0000_0111, 7, 1'b1, 1'b1, 1'b1, 7, 1'b0});

        // Reset state
        #12;
        chk("rst_up_rdy", int'(up_rdy), 0);
        chk("rst_down_vld", int'(down_vld), 0);
        chk("rst_down_parity", int'(down_parity), 0);
        chk("rst_down_len", int'(down_len), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_up_rdy", int'(up_rdy), 1);
        down_rdy = 1'b1;

        // Table frames back to back
        foreach (tbl[i]) send_frame(tbl[i], 0, w0);
        wait_empty();

        // Latency and turnaround
        f = '{8'b1111_1111, 8, 1'b0, 1'b1, 1'b0, 8, 1'b1};
        send_frame(f, 0, w0);
        chk("vld_1cyc_after_last", int'(down_vld), 1);
        chk("rdy_low_in_hold", int'(up_rdy), 0);
        f = '{8'b0000_0001, 1, 1'b1, 1'b1, 1'b1, 1, 1'b0};
        send_frame(f, 0, w0);
        chk("next_frame_wait_cycles", w0, 1);
        wait_empty();

        // Backpressure
        down_rdy = 1'b0;
        f = '{8'b0000_0100, 3, 1'b1, 1'b1, 1'b1, 3, 1'b0};
        send_frame(f, 0, w0);
        for (int c = 0; c < 5; c++) begin
            up_vld = (c % 2 == 0); up_data = 1'b1; up_last = 1'($urandom);
            @(negedge clk);
            chk("bp_up_rdy", int'(up_rdy), 0);
            chk("bp_down_vld", int'(down_vld), 1);
            chk("bp_down_parity", int'(down_parity), 1);
            chk("bp_down_len", int'(down_len), 3);
            @(posedge clk); #1;
        end
        up_vld = 1'b0; up_last = 1'b0;
        down_rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_vld_clear", int'(down_vld), 0);
        chk("bp_release_up_rdy", int'(up_rdy), 1);
        wait_empty();

        // Bubbles with random idle gaps and noise on data/last
        f = '{8'b0101_0111, 8, 1'b0, 1'b0, 1'b1, 8, 1'b1};
        send_frame(f, 3, w0);
        wait_empty();

        // Asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, w0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_up_rdy", int'(up_rdy), 0);
        chk("midrst_down_vld", int'(down_vld), 0);
        chk("midrst_down_parity", int'(down_parity), 0);
        chk("midrst_down_len", int'(down_len), 0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        f = '{8'b1011_0000, 8, 1'b0, 1'b1, 1'b1, 8, 1'b0};
        send_frame(f, 0, w0);
        wait_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
